// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } ifu_state_t;

  localparam logic [31:0] IFU_NOP     = 32'h0000_0013;
  localparam logic [31:0] IFU_PC_STEP = 32'd4;

  // Instruction addresses must be word aligned.
  function automatic logic ifu_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/ifu_timeout_counter.sv
// Counts consecutive request cycles without a response; flags the last allowed cycle.
module ifu_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] count;

  // Cycle counter: clear has priority over counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Current cycle is the TIMEOUT_CYCLES-th request cycle without a response.
  always_comb begin
    expired = enable && !clear && (count == LAST);
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, keeps one outstanding imem read,
// holds the fetched word for decode and applies CU redirects.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instruction,
  output logic        Fetch_ready,
  input  logic        IDU_ready,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  ifu_state_t  state;
  logic [31:0] pc;
  logic        discard;
  logic        timer_clear;
  logic        timer_en;
  logic        expired;
  logic        redirect_bad;
  logic [31:0] next_pc;

  // Timer runs only in REQ; leaving REQ or any response restarts it.
  always_comb begin
    timer_en     = (state == REQ);
    timer_clear  = (state != REQ) || imem_rvalid;
    redirect_bad = redirect_valid && ifu_misaligned(redirect_pc);
    next_pc      = redirect_valid ? redirect_pc : (pc + IFU_PC_STEP);
  end

  ifu_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timeout (
    .clk    (soc_clk),
    .rst_n  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(expired)
  );

  // Fetch FSM with registered request, hold and fault outputs.
  always_ff @(posedge soc_clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instruction <= IFU_NOP;
      Fetch_ready <= 1'b0;
      pc_out      <= RESET_PC;
      fetch_fault <= 1'b0;
      discard     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_bad) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
          end else begin
            if (redirect_valid) pc <= redirect_pc;
            if (fetch_en) begin
              imem_addr <= redirect_valid ? redirect_pc : pc;
              imem_req  <= 1'b1;
              state     <= REQ;
            end
          end
        end

        REQ: begin
          if (redirect_bad) begin
            state       <= FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            discard     <= 1'b0;
          end else if (imem_rvalid) begin
            if (redirect_valid) begin
              // Response arrived for the superseded address: reissue at target.
              pc        <= redirect_pc;
              imem_addr <= redirect_pc;
              discard   <= 1'b0;
            end else if (discard) begin
              // Stale response for a pre-redirect request; pc already holds the target.
              imem_addr <= pc;
              discard   <= 1'b0;
            end else begin
              instruction <= imem_rdata;
              pc_out      <= imem_addr;
              Fetch_ready <= 1'b1;
              imem_req    <= 1'b0;
              state       <= HOLD;
            end
          end else if (expired) begin
            state       <= FAULT;
            imem_req    <= 1'b0;
            fetch_fault <= 1'b1;
            discard     <= 1'b0;
          end else if (redirect_valid) begin
            // Request stays on the bus with its old address until it completes.
            pc      <= redirect_pc;
            discard <= 1'b1;
          end
        end

        HOLD: begin
          if (redirect_bad) begin
            state       <= FAULT;
            Fetch_ready <= 1'b0;
            fetch_fault <= 1'b1;
          end else if (redirect_valid || IDU_ready) begin
            // Redirect wins over a simultaneous handshake; the held word is dropped.
            Fetch_ready <= 1'b0;
            pc          <= next_pc;
            if (fetch_en) begin
              imem_addr <= next_pc;
              imem_req  <= 1'b1;
              state     <= REQ;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state       <= FAULT;
          imem_req    <= 1'b0;
          Fetch_ready <= 1'b0;
          fetch_fault <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed stimulus, a memory responder,
// and a transaction-level model checked every cycle on the falling edge.
module tb_ifu_fetch;
  import ifu_pkg::*;

  localparam int          TO  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] instruction;
  logic        Fetch_ready;
  logic        IDU_ready = 1'b0;
  logic [31:0] pc_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  ifu_fetch #(
    .RESET_PC      (RPC),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (8)
  ) dut (
    .soc_clk       (soc_clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .instruction   (instruction),
    .Fetch_ready   (Fetch_ready),
    .IDU_ready     (IDU_ready),
    .pc_out        (pc_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_fault   (fetch_fault)
  );

  always #5 soc_clk = ~soc_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
  endfunction

  // Memory: answers a request once it has been seen for more than mem_lat cycles.
  int mem_lat = 1;
  bit mem_on  = 1'b1;
  int wait_cnt = 0;
  always @(posedge soc_clk) begin
    #1;
    if (!reset) begin
      imem_rvalid = 1'b0;
      wait_cnt    = 0;
    end else if (imem_rvalid) begin
      imem_rvalid = 1'b0;
      wait_cnt    = 0;
    end else if (imem_req && mem_on) begin
      wait_cnt++;
      if (wait_cnt > mem_lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Model: next address to be delivered, sticky fault, unanswered request cycles.
  logic [31:0] m_pc = RPC;
  bit          m_fault = 1'b0;
  int          m_wait = 0;
  bit          p_fr = 1'b0, p_req = 1'b0, p_rv = 1'b0;
  logic [31:0] p_instr = '0, p_pcout = '0, p_addr = '0;

  always @(negedge soc_clk) begin
    if (!reset) begin
      m_pc = RPC; m_fault = 1'b0; m_wait = 0;
      p_fr = 1'b0; p_req = 1'b0; p_rv = 1'b0;
      chk("rst_req", imem_req, 0);
      chk("rst_fr", Fetch_ready, 0);
    end else begin
      chk("m_fault", fetch_fault, m_fault);
      if (m_fault) begin
        chk("m_fault_req", imem_req, 0);
        chk("m_fault_fr", Fetch_ready, 0);
      end
      if (Fetch_ready) begin
        chk("m_hold_req", imem_req, 0);
        if (!p_fr) begin
          chk("m_deliver_pc", pc_out, m_pc);
          chk("m_deliver_instr", instruction, mem_word(m_pc));
        end else begin
          chk("m_hold_instr", instruction, p_instr);
          chk("m_hold_pc", pc_out, p_pcout);
        end
      end
      if (p_req && imem_req && !p_rv) chk("m_addr_stable", imem_addr, p_addr);
      if (!m_fault) begin
        if (redirect_valid) begin
          if (redirect_pc[1:0] != 2'b00) m_fault = 1'b1;
          else m_pc = redirect_pc;
        end else if (Fetch_ready && IDU_ready) begin
          m_pc = m_pc + 32'd4;
        end
        if (imem_req && !imem_rvalid) begin
          m_wait++;
          if (m_wait >= TO) m_fault = 1'b1;
        end else begin
          m_wait = 0;
        end
      end
      p_fr = Fetch_ready; p_req = imem_req; p_rv = imem_rvalid;
      p_instr = instruction; p_pcout = pc_out; p_addr = imem_addr;
    end
  end

  task automatic tick();
    @(posedge soc_clk);
    #1;
  endtask

  task automatic wait_fr(input string name);
    int n = 0;
    while (!Fetch_ready && n < 20) begin
      tick();
      n++;
    end
    chk(name, Fetch_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (2) tick();
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_instr", instruction, 32'h0000_0013);
    chk("reset_fr", Fetch_ready, 0);
    chk("reset_pcout", pc_out, 32'h0);
    chk("reset_fault", fetch_fault, 0);
    reset = 1'b1;
    tick();

    // First fetch and latency.
    fetch_en = 1'b1;
    tick();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_fr_n", Fetch_ready, 0);
    tick();
    chk("first_fr_n1", Fetch_ready, 0);
    tick();
    chk("first_fr_n2", Fetch_ready, 1);
    chk("first_instr", instruction, 32'h0050_0093);
    chk("first_pcout", pc_out, 32'h0);

    // Decode stalls for five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_fr", Fetch_ready, 1);
      chk("stall_req", imem_req, 0);
      chk("stall_instr", instruction, 32'h0050_0093);
      chk("stall_pcout", pc_out, 32'h0);
    end
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("hs_fr", Fetch_ready, 0);
    chk("hs_req", imem_req, 1);
    chk("hs_addr", imem_addr, 32'h4);
    wait_fr("fr_4");
    chk("pcout_4", pc_out, 32'h4);
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("req8_addr", imem_addr, 32'h8);
    chk("req8_req", imem_req, 1);

    // Redirect while the request for 8 is outstanding.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("disc_old_addr", imem_addr, 32'h8);
    tick();
    chk("disc_drop_fr", Fetch_ready, 0);
    chk("disc_new_addr", imem_addr, 32'h100);
    chk("disc_req", imem_req, 1);
    wait_fr("fr_100");
    chk("pcout_100", pc_out, 32'h100);
    chk("instr_100", instruction, 32'h1357_9ADF);
    fetch_en  = 1'b0;
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("park_req", imem_req, 0);
    chk("park_fr", Fetch_ready, 0);
    tick();
    chk("park_req2", imem_req, 0);

    // PC wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    fetch_en       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("top_addr", imem_addr, 32'hFFFF_FFFC);
    wait_fr("fr_top");
    chk("pcout_top", pc_out, 32'hFFFF_FFFC);
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_req", imem_req, 1);

    // Asynchronous reset in the middle of a request.
    #2;
    reset = 1'b0;
    #1;
    chk("async_req", imem_req, 0);
    chk("async_pcout", pc_out, 32'h0);
    fetch_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Misaligned redirect -> sticky fault.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("mis_fault", fetch_fault, 1);
    chk("mis_req", imem_req, 0);
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fault_sticky", fetch_fault, 1);
      chk("fault_noreq", imem_req, 0);
    end
    redirect_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("fault_clr", fetch_fault, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_fetch_req", imem_req, 1);
    chk("rst_fetch_addr", imem_addr, 32'h0);
    wait_fr("fr_after_fault");
    fetch_en  = 1'b0;
    IDU_ready = 1'b1;
    tick();
    IDU_ready = 1'b0;
    tick();

    // Timeout with no response.
    mem_on   = 1'b0;
    fetch_en = 1'b1;
    tick();
    chk("to_req", imem_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_nofault", fetch_fault, 0);
      chk("to_req_hi", imem_req, 1);
    end
    tick();
    chk("to_fault", fetch_fault, 1);
    chk("to_req_lo", imem_req, 0);

    // Response in the last allowed request cycle.
    reset = 1'b0;
    tick();
    mem_on  = 1'b1;
    mem_lat = 3;
    reset   = 1'b1;
    tick();
    chk("late_req", imem_req, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_nofault", fetch_fault, 0);
      chk("late_wait", imem_req, 1);
    end
    tick();
    chk("late_fr", Fetch_ready, 1);
    chk("late_fault", fetch_fault, 0);
    chk("late_pcout", pc_out, 32'h0);

    // Redirect in HOLD beats a simultaneous handshake.
    mem_lat        = 1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    IDU_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    IDU_ready      = 1'b0;
    chk("hredir_fr", Fetch_ready, 0);
    chk("hredir_addr", imem_addr, 32'h40);
    wait_fr("fr_40");
    chk("pcout_40", pc_out, 32'h40);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
